// File: rtl/dpc_pkg.sv
// Shared constants and types for the DPC bad-pixel list upload path.
// Header word layout: {magic, frame sequence id, entry count}.
package dpc_pkg;

   localparam logic [7:0]  HDR_MAGIC = 8'hA5;
   localparam int unsigned ENTRY_W   = 32;
   localparam int unsigned COORD_W   = 16;
   localparam int unsigned HDR_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      DATA
   } upload_state_e;

   function automatic logic [ENTRY_W-1:0] make_header(input logic [7:0]           fid,
                                                      input logic [HDR_CNT_W-1:0] cnt);
      return {HDR_MAGIC, fid, cnt};
   endfunction

endpackage

// File: rtl/dpc_skid_fifo.sv
// Two-entry first-word-fall-through FIFO; an empty FIFO passes its input straight
// to the output so a BRAM word can be presented in the cycle it arrives.
module dpc_skid_fifo #(
   parameter int unsigned W = 33
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [1:0]   count
);

   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   count_q, count_d;
   logic         empty, bypass, store, pop_mem;

   always_comb begin
      empty     = (count_q == 2'd0);
      in_ready  = (count_q != 2'd2);
      out_valid = !empty || in_valid;
      out_data  = empty ? in_data : mem_q[rd_ptr_q];
      bypass    = empty && in_valid && out_ready;
      store     = in_valid && in_ready && !bypass;
      pop_mem   = out_valid && out_ready && !empty;
      mem_d     = mem_q;
      if (store) begin
         mem_d[wr_ptr_q] = in_data;
      end
      wr_ptr_d = wr_ptr_q ^ store;
      rd_ptr_d = rd_ptr_q ^ pop_mem;
      count_d  = count_q + 2'(store) - 2'(pop_mem);
      count    = count_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/dpc_bp_list_uploader.sv
// Reads the auto bad-pixel list after each frame and streams it to the host as one
// AXI4-Stream packet: a header word followed by one word per list entry.
module dpc_bp_list_uploader
   import dpc_pkg::*;
#(
   parameter int unsigned AUTO_BP_BIT = 8,
   parameter int unsigned FRAME_ID_W  = 8
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic                   enable,
   input  logic                   frame_done,
   input  logic                   sof_in,
   input  logic [AUTO_BP_BIT:0]   bp_count,
   output logic [AUTO_BP_BIT-1:0] rd_addr,
   input  logic [31:0]            rd_data,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic [31:0]            m_axis_tdata,
   output logic                   m_axis_tlast,
   output logic                   busy,
   output logic                   stale_err,
   output logic [7:0]             dropped_cnt,
   input  logic                   clear_status
);

   localparam int unsigned CNT_W = AUTO_BP_BIT + 1;

   upload_state_e         state_q, state_d;
   logic [CNT_W-1:0]      n_q, n_d;
   logic [CNT_W-1:0]      addr_q, addr_d;
   logic                  inflight_q, inflight_d;
   logic                  inflight_last_q, inflight_last_d;
   logic [FRAME_ID_W-1:0] frame_id_q, frame_id_d;
   logic                  stale_q, stale_d;
   logic [7:0]            dropped_q, dropped_d;

   logic                  fifo_in_ready, fifo_out_valid, fifo_out_ready;
   logic [ENTRY_W:0]      fifo_out_data;
   logic [1:0]            fifo_occ;
   logic                  issue, hs, is_busy;

   dpc_skid_fifo #(
      .W (ENTRY_W + 1)
   ) u_fifo (
      .clk       (aclk),
      .rst       (areset),
      .in_valid  (inflight_q),
      .in_ready  (fifo_in_ready),
      .in_data   ({inflight_last_q, rd_data}),
      .out_valid (fifo_out_valid),
      .out_ready (fifo_out_ready),
      .out_data  (fifo_out_data),
      .count     (fifo_occ)
   );

   always_comb begin
      is_busy        = (state_q != IDLE);
      m_axis_tvalid  = 1'b0;
      m_axis_tdata   = '0;
      m_axis_tlast   = 1'b0;
      fifo_out_ready = 1'b0;
      case (state_q)
         HDR: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = make_header(8'(frame_id_q), HDR_CNT_W'(n_q));
            m_axis_tlast  = (n_q == '0);
         end
         DATA: begin
            m_axis_tvalid  = fifo_out_valid;
            m_axis_tdata   = fifo_out_data[ENTRY_W-1:0];
            m_axis_tlast   = fifo_out_valid && fifo_out_data[ENTRY_W];
            fifo_out_ready = m_axis_tready;
         end
         default: ;
      endcase
      hs = m_axis_tvalid && m_axis_tready;

      // Reads stay bounded by free FIFO space so a stalled stream never overflows the skid.
      issue = is_busy && (addr_q < n_q) && fifo_in_ready &&
              ((fifo_occ + 2'(inflight_q)) < 2'd2);

      state_d         = state_q;
      n_d             = n_q;
      addr_d          = issue ? addr_q + CNT_W'(1) : addr_q;
      inflight_d      = issue;
      inflight_last_d = issue && (addr_q == n_q - CNT_W'(1));
      frame_id_d      = frame_id_q;

      case (state_q)
         IDLE: begin
            if (frame_done && enable) begin
               n_d     = bp_count;
               addr_d  = '0;
               state_d = HDR;
            end
         end
         HDR: begin
            if (hs) begin
               if (n_q == '0) begin
                  state_d    = IDLE;
                  frame_id_d = frame_id_q + FRAME_ID_W'(1);
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (hs && m_axis_tlast) begin
               state_d    = IDLE;
               frame_id_d = frame_id_q + FRAME_ID_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      stale_d   = stale_q;
      dropped_d = dropped_q;
      if (clear_status) begin
         stale_d   = 1'b0;
         dropped_d = '0;
      end else begin
         if (sof_in && is_busy) begin
            stale_d = 1'b1;
         end
         if (frame_done && is_busy && (dropped_q != 8'hFF)) begin
            dropped_d = dropped_q + 8'd1;
         end
      end

      rd_addr     = addr_q[AUTO_BP_BIT-1:0];
      busy        = is_busy;
      stale_err   = stale_q;
      dropped_cnt = dropped_q;
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q         <= IDLE;
         n_q             <= '0;
         addr_q          <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         frame_id_q      <= '0;
         stale_q         <= 1'b0;
         dropped_q       <= '0;
      end else begin
         state_q         <= state_d;
         n_q             <= n_d;
         addr_q          <= addr_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         frame_id_q      <= frame_id_d;
         stale_q         <= stale_d;
         dropped_q       <= dropped_d;
      end
   end

endmodule
